// File: rtl/router_input_buffer.sv
// Credit-based router input port: DEPTH-entry flit FIFO, XY route request
// for the packet at the head, and a one-cycle credit pulse per dequeued flit.
module router_input_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [3:0]               position,
    input  logic [WIDTH-1:0]         in,
    input  logic                     vi,
    output logic                     co,
    output logic [WIDTH-1:0]         dout,
    output logic                     out_valid,
    output logic [4:0]               route_req,
    input  logic                     grant,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     proto_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    // dest/pos are {x[1:0], y[1:0]}; result is one-hot {L, W, S, E, N}
    function automatic logic [4:0] f_xy_route(input logic [3:0] dest, input logic [3:0] pos);
        logic [4:0] r;
        if (dest[3:2] > pos[3:2])      r = 5'b00010;
        else if (dest[3:2] < pos[3:2]) r = 5'b01000;
        else if (dest[1:0] > pos[1:0]) r = 5'b00001;
        else if (dest[1:0] < pos[1:0]) r = 5'b00100;
        else                           r = 5'b10000;
        return r;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [4:0]       r_route;
    logic             r_co;
    logic             r_overflow;
    logic             r_proto_err;
    state_t           r_state;

    logic [WIDTH-1:0] w_head;
    logic [1:0]       w_type;
    logic             w_valid;
    logic             w_full;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;
    logic             w_is_hdr;
    logic             w_is_tail;
    logic             w_err;
    logic [4:0]       w_head_route;

    assign w_head       = r_mem[r_rptr];
    assign w_type       = w_head[19:18];
    assign w_is_hdr     = w_type[0];
    assign w_is_tail    = (w_type == 2'b10);
    assign w_valid      = (r_count != '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_rd         = grant && w_valid;
    assign w_wr         = vi && (!w_full || w_rd);
    assign w_drop       = vi && w_full && !w_rd;
    assign w_head_route = f_xy_route(w_head[17:14], position);

    // A head/single while mid-packet, or a body/tail with no open packet, is a framing error
    assign w_err = w_valid && (((r_state == S_IDLE) && !w_is_hdr) ||
                               ((r_state == S_ACTIVE) && w_is_hdr));

    always_comb begin
        route_req = 5'b00000;
        if (w_valid) begin
            if (r_state == S_ACTIVE) route_req = r_route;
            else if (w_is_hdr)       route_req = w_head_route;
        end
    end

    assign dout      = w_valid ? w_head : '0;
    assign out_valid = w_valid;
    assign count     = r_count;
    assign co        = r_co;
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_route     <= 5'b00000;
            r_co        <= 1'b0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
            r_state     <= S_IDLE;
        end else begin
            r_co <= w_rd;
            if (w_wr) r_wptr <= r_wptr + PW'(1);
            if (w_rd) r_rptr <= r_rptr + PW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow  <= 1'b1;
            if (w_err)  r_proto_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_rd && (w_type == 2'b01)) begin
                        r_route <= w_head_route;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_rd && (w_is_tail || w_is_hdr)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Flit storage carries no reset; dout is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= in;
    end
endmodule

// File: tb/tb_router_input_buffer.sv
// Self-checking bench for router_input_buffer: directed scenarios plus
// randomized traffic against a queue-based packet model.
module tb_router_input_buffer;
    localparam int DEPTH = 4;
    localparam int WIDTH = 20;

    logic             clk = 1'b0;
    logic             RST = 1'b0;
    logic [3:0]       position = 4'b0101;
    logic [WIDTH-1:0] in = '0;
    logic             vi = 1'b0;
    logic             grant = 1'b0;
    logic             co;
    logic [WIDTH-1:0] dout;
    logic             out_valid;
    logic [4:0]       route_req;
    logic [2:0]       count;
    logic             overflow;
    logic             proto_err;

    router_input_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .RST(RST), .position(position), .in(in), .vi(vi), .co(co),
        .dout(dout), .out_valid(out_valid), .route_req(route_req), .grant(grant),
        .count(count), .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: flit queue plus "inside a packet" flag and its route
    logic [WIDTH-1:0] q[$];
    bit               m_in_pkt;
    logic [4:0]       m_route;
    bit               m_co, m_ovf, m_perr;

    function automatic logic [4:0] xy(input logic [WIDTH-1:0] f, input logic [3:0] p);
        int dx, dy, x, y;
        dx = int'(f[17:16]); dy = int'(f[15:14]); x = int'(p[3:2]); y = int'(p[1:0]);
        if (dx > x) return 5'b00010;
        if (dx < x) return 5'b01000;
        if (dy > y) return 5'b00001;
        if (dy < y) return 5'b00100;
        return 5'b10000;
    endfunction

    function automatic logic [WIDTH-1:0] flit(input int t, input int dx, input int dy, input int pl);
        logic [WIDTH-1:0] f;
        f = {2'(t), 2'(dx), 2'(dy), 14'(pl)};
        return f;
    endfunction

    task automatic model_clear();
        q.delete(); m_in_pkt = 0; m_route = '0; m_co = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] exp_route();
        logic [1:0] t;
        if (q.size() == 0) return 5'b0;
        t = q[0][19:18];
        if (m_in_pkt) return m_route;
        if (t == 2'b01 || t == 2'b11) return xy(q[0], position);
        return 5'b0;
    endfunction

    task automatic compare_all();
        check("count", 32'(count), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("dout", 32'(dout), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        check("route_req", 32'(route_req), 32'(exp_route()));
        check("co", 32'(co), 32'(m_co));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("proto_err", 32'(proto_err), 32'(m_perr));
    endtask

    // Advance one clock: apply the spec rules to the inputs seen at the edge
    task automatic step();
        bit rd, hdr;
        logic [1:0] t;
        @(posedge clk);
        if (!RST) begin
            model_clear();
        end else begin
            rd = grant && (q.size() != 0);
            if (q.size() != 0) begin
                t = q[0][19:18];
                hdr = (t == 2'b01) || (t == 2'b11);
                if (m_in_pkt == hdr) m_perr = 1;
            end
            if (rd) begin
                t = q[0][19:18];
                if (!m_in_pkt) begin
                    if (t == 2'b01) begin m_in_pkt = 1; m_route = xy(q[0], position); end
                end else if (t != 2'b00) begin
                    m_in_pkt = 0;
                end
                void'(q.pop_front());
            end
            if (vi) begin
                if (q.size() < DEPTH) q.push_back(in);
                else m_ovf = 1;
            end
            m_co = rd;
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset(input logic [3:0] pos);
        RST = 1'b0; vi = 0; grant = 0;
        #1;
        model_clear();
        compare_all();
        position = pos;
        step(); step();
        RST = 1'b1;
    endtask

    int pulses;

    initial begin
        model_clear();
        #2;
        compare_all();
        step();
        RST = 1'b1;
        step();

        // Single flit to (2,1) at (1,1): east
        in = flit(3, 2, 1, 14'h123); vi = 1; step(); vi = 0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_route", 32'(route_req), 32'b00010);
        grant = 1; step(); grant = 0;
        check("t1_co", 32'(co), 32'd1);
        check("t1_count", 32'(count), 32'd0);
        step();
        check("t1_co_off", 32'(co), 32'd0);

        // Four-flit packet to (1,3) at (1,1), grant held: north throughout
        pulses = 0; grant = 1;
        for (int i = 0; i < 4; i++) begin
            in = flit((i == 0) ? 1 : (i == 3) ? 2 : 0, 1, 3, i); vi = 1;
            step();
            check("t2_route", 32'(route_req), 32'b00001);
            pulses += int'(co);
        end
        vi = 0;
        for (int i = 0; i < 3; i++) begin step(); pulses += int'(co); end
        grant = 0;
        check("t2_pulses", 32'(pulses), 32'd4);
        check("t2_perr", 32'(proto_err), 32'd0);

        // Overflow: five writes with no grant
        for (int i = 0; i < 5; i++) begin
            in = flit(3, 1, 1, 16 + i); vi = 1; step();
        end
        vi = 0;
        check("t3_count", 32'(count), 32'd4);
        check("t3_ovf", 32'(overflow), 32'd1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            check("t3_order", 32'(dout[13:0]), 32'(16 + i));
            grant = 1; step(); grant = 0;
            pulses += int'(co);
        end
        step(); pulses += int'(co);
        check("t3_pulses", 32'(pulses), 32'd4);

        // Full FIFO with simultaneous write and read across the pointer wrap
        do_reset(4'b0101);
        for (int i = 0; i < 4; i++) begin in = flit(3, 0, 0, 32 + i); vi = 1; step(); end
        in = flit(3, 0, 0, 36); vi = 1; grant = 1; step(); vi = 0; grant = 0;
        check("t4_count", 32'(count), 32'd4);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_co", 32'(co), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t4_order", 32'(dout[13:0]), 32'(33 + i));
            grant = 1; step(); grant = 0;
        end

        // Body flit with no open packet
        in = flit(0, 3, 3, 7); vi = 1; step(); vi = 0;
        check("t5_route", 32'(route_req), 32'd0);
        step();
        check("t5_perr", 32'(proto_err), 32'd1);
        grant = 1; step(); grant = 0;
        check("t5_co", 32'(co), 32'd1);
        check("t5_empty", 32'(out_valid), 32'd0);

        // Reset with three flits of a packet buffered
        do_reset(4'b0101);
        for (int i = 0; i < 3; i++) begin in = flit((i == 0) ? 1 : 0, 2, 2, i); vi = 1; step(); end
        vi = 0;
        do_reset(4'b1001);
        check("t6_count", 32'(count), 32'd0);
        check("t6_co", 32'(co), 32'd0);
        in = flit(3, 2, 1, 99); vi = 1; step(); vi = 0;
        check("t6_local", 32'(route_req), 32'b10000);
        grant = 1; step(); grant = 0;

        // Randomized traffic, mostly well-formed with occasional stray types
        for (int seg = 0; seg < 6; seg++) begin
            do_reset(4'($urandom));
            for (int c = 0; c < 300; c++) begin
                vi    = ($urandom_range(0, 3) != 0);
                grant = ($urandom_range(0, 2) != 0);
                in    = flit($urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 16383));
                step();
            end
            vi = 0; grant = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/router_input_buffer.md
# router_input_buffer

Credit-based receive end of a router link. It accepts 20-bit flits with a valid strobe from an upstream sender (a neighbouring router or the local processor element) and holds them in a DEPTH-entry FIFO. It computes the XY output-port request for each packet and returns one credit pulse upstream for every flit the crossbar dequeues. One instance sits on each of the five router input ports.

## Interface
- DEPTH, 4: FIFO entries, power of two, ≥2; equals the upstream sender's initial credit count.
- WIDTH, 20: flit width; fixed flit format below.
- clk  input  1  clock; all state on rising edge.
- RST  input  1  reset; asynchronous, active-low.
- position  input  4  this router's coordinate; [3:2]=x, [1:0]=y; static after reset.
- in  input  WIDTH  incoming flit.
- vi  input  1  flit valid; one flit per cycle when high.
- co  output  1  credit return; one-cycle pulse per freed slot.
- dout  output  WIDTH  flit at FIFO head.
- out_valid  output  1  FIFO non-empty.
- route_req  output  5  one-hot port request; bit0=N, bit1=E, bit2=S, bit3=W, bit4=Local; zero when !out_valid.
- grant  input  1  crossbar dequeues the head flit this cycle.
- count  output  $clog2(DEPTH)+1  occupancy.
- overflow  output  1  sticky: a flit arrived when the FIFO was full with no simultaneous dequeue.
- proto_err  output  1  sticky: packet framing violation.

## Operation
- Flit format: [19:18] type (00 body, 01 head, 10 tail, 11 single); [17:14] destination (x=[17:16], y=[15:14]); [13:0] payload.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH.
  - Write when vi=1.
  - Read when grant=1 and out_valid=1.
  - grant with out_valid=0 is ignored: no pop, no credit.
- Full and vi=1 with a simultaneous read: the write is accepted and count stays DEPTH.
- Full and vi=1 without a read: the flit is dropped, overflow is set, and pointers are unchanged.
- Empty and vi=1 with grant=1: the grant is ignored, because out_valid is still 0.
- Routing is XY. Let dx,dy be the destination and x,y the position.
  - dx>x: E. dx<x: W.
  - dx==x: dy>y gives N, dy<y gives S, otherwise Local.
- Packet FSM:
  - IDLE: route_req is computed combinationally from dout when dout is a head or single flit.
    - Head dequeued: latch route, go to ACTIVE.
    - Single dequeued: stay IDLE.
    - Body or tail at FIFO head in IDLE: set proto_err, route_req=0, pop and discard on grant. A credit is still returned.
  - ACTIVE: route_req is driven from the latched route for body and tail flits.
    - Tail dequeued: go to IDLE.
    - Head or single at FIFO head in ACTIVE: set proto_err and drive the latched route. The flit is forwarded, and the FSM goes to IDLE when that flit is dequeued.
- co is registered: high exactly in the cycle after each read, including discarded flits.
- Overflow-dropped flits return no credit.

## Timing
- Reset (RST=0, asynchronous), all values immediate:
  - Pointers and count to 0; FSM to IDLE; latched route to 0.
  - co=0, out_valid=0, route_req=0, dout=0, overflow=0, proto_err=0.
- Reset mid-packet discards the buffered flits and the FSM state. No credits are returned for the discarded flits; the upstream sender must also reset.
- Write-to-visible latency: a flit sampled on edge n appears on dout, with out_valid=1 and route_req valid, after edge n.
- Read: the head advances on the same edge that samples grant. dout shows the next entry after that edge. co=1 for the cycle following that edge.
- Throughput: one write and one read per cycle sustained.
  - With DEPTH credits and one-cycle credit return, the link runs at full rate when upstream round-trip ≤ DEPTH.
- count updates on each edge: +1 write only, −1 read only, unchanged on both or neither.
- overflow and proto_err clear only on reset.

## Test plan
- Reset, then single flit type=11, dest (2,1), position=4'b0101. Response:
  - out_valid=1 one cycle after the write; route_req=00010 (E).
  - After grant: co pulses for one cycle, count returns to 0.
- 4-flit packet (head, body, body, tail) to dest (1,3) at position (1,1), grant held high. Response:
  - route_req=00001 (N) on all four flits.
  - Four co pulses; FSM back to IDLE after the tail.
- Fill 4 flits with grant=0, then a 5th with vi=1. Response:
  - count=4, overflow=1, 5th flit absent.
  - Draining gives exactly 4 co pulses in order.
- Full FIFO with vi=1 and grant=1 in the same cycle. Response:
  - count stays 4, no overflow, one co pulse, FIFO order preserved across pointer wrap.
- Body flit at the head while IDLE. Response:
  - proto_err=1, route_req=0.
  - On grant the flit is discarded and co still pulses.
- Assert RST mid-packet with 3 flits buffered. Response:
  - Outputs go to 0 immediately, with no co pulses.
  - A new single flit to dest==position after release gives route_req=10000 (Local).
